// File: rtl/cpu_control_fsm_if.sv
// Control-word bus between the instruction sequencer (master) and the datapath (slave).
// The master side reads IR, the memory handshake and the flags, and drives the control word.
interface cpu_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       IR;
  logic              mem_ready;
  logic              Z;
  logic              N;
  logic [1:0]        PS;
  logic              IR_L;
  logic [2:0]        AA;
  logic [2:0]        BA;
  logic [2:0]        DA;
  logic              WR;
  logic              Clr;
  logic [4:0]        FS;
  logic              Cin;
  logic [4:0]        MuxD;
  logic              MuxA;
  logic [DATA_W-1:0] K;
  logic              MW;
  logic [1:0]        SS;
  logic [2:0]        state_o;

  modport master (
    input  IR, mem_ready, Z, N,
    output PS, IR_L, AA, BA, DA, WR, Clr, FS, Cin, MuxD, MuxA, K, MW, SS, state_o
  );

  modport slave (
    output IR, mem_ready, Z, N,
    input  PS, IR_L, AA, BA, DA, WR, Clr, FS, Cin, MuxD, MuxA, K, MW, SS, state_o
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: INIT -> FETCH -> EXEC (-> MEM) -> FETCH, with HALT.
// The control word is decoded combinationally from the registered state and IR.
module cpu_control_fsm #(
  parameter int DATA_W     = 16,
  parameter int IMM_SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC  = 3'b010,
    ST_MEM   = 3'b011,
    ST_HALT  = 3'b100
  } state_t;

  state_t            state_r;
  state_t            next_state_s;

  logic [1:0]        ps_s;
  logic              ir_l_s;
  logic [2:0]        aa_s;
  logic [2:0]        ba_s;
  logic [2:0]        da_s;
  logic              wr_s;
  logic              clr_s;
  logic [4:0]        fs_s;
  logic              cin_s;
  logic [4:0]        muxd_s;
  logic              muxa_s;
  logic [DATA_W-1:0] k_s;
  logic              mw_s;
  logic              taken_s;

  // Widen the 11-bit immediate field; sign_ext replicates bit 10 into the upper bits.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [10:0] imm, input logic sign_ext);
    logic [DATA_W-1:0] ext_v;
    if (sign_ext) begin
      ext_v = {{(DATA_W-11){imm[10]}}, imm};
    end else begin
      ext_v = {{(DATA_W-11){1'b0}}, imm};
    end
    return ext_v;
  endfunction

  // State register; an asserted rst_n forces INIT immediately, aborting any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control-word decode.
  always_comb begin
    next_state_s = state_r;
    ps_s         = 2'b00;
    ir_l_s       = 1'b0;
    aa_s         = 3'b000;
    ba_s         = 3'b000;
    da_s         = 3'b000;
    wr_s         = 1'b0;
    clr_s        = 1'b0;
    fs_s         = 5'b00000;
    cin_s        = 1'b0;
    muxd_s       = 5'b00000;
    muxa_s       = 1'b0;
    k_s          = {DATA_W{1'b0}};
    mw_s         = 1'b0;
    taken_s      = 1'b0;

    case (state_r)
      ST_INIT: begin
        clr_s        = 1'b1;
        ps_s         = 2'b11;
        next_state_s = ST_FETCH;
      end

      ST_FETCH: begin
        ir_l_s = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (bus.IR[15:14])
          2'b00: begin
            da_s         = bus.IR[13:11];
            aa_s         = bus.IR[10:8];
            ba_s         = bus.IR[7:5];
            fs_s         = {1'b0, bus.IR[3:0]};
            cin_s        = bus.IR[4];
            muxd_s       = 5'b00001;
            wr_s         = 1'b1;
            ps_s         = 2'b01;
            next_state_s = ST_FETCH;
          end

          2'b01: begin
            // PC advances here so MEM never touches it.
            aa_s         = bus.IR[10:8];
            ba_s         = bus.IR[7:5];
            da_s         = bus.IR[13:11];
            ps_s         = 2'b01;
            next_state_s = ST_MEM;
          end

          2'b10: begin
            k_s = extend_imm(bus.IR[10:0], 1'b1);
            case (bus.IR[13:11])
              3'b000:  taken_s = 1'b1;
              3'b001:  taken_s = bus.Z;
              3'b010:  taken_s = ~bus.Z;
              3'b011:  taken_s = bus.N;
              default: taken_s = 1'b0;
            endcase
            if (bus.IR[13:11] == 3'b111) begin
              ps_s         = 2'b00;
              next_state_s = ST_HALT;
            end else if (taken_s) begin
              ps_s         = 2'b10;
              next_state_s = ST_FETCH;
            end else begin
              ps_s         = 2'b01;
              next_state_s = ST_FETCH;
            end
          end

          2'b11: begin
            da_s         = bus.IR[13:11];
            k_s          = extend_imm(bus.IR[10:0], IMM_SIGNED != 0);
            fs_s         = 5'b01010;
            muxa_s       = 1'b1;
            muxd_s       = 5'b00100;
            wr_s         = 1'b1;
            ps_s         = 2'b01;
            next_state_s = ST_FETCH;
          end

          default: begin
            next_state_s = ST_INIT;
          end
        endcase
      end

      ST_MEM: begin
        aa_s = bus.IR[10:8];
        ba_s = bus.IR[7:5];
        da_s = bus.IR[13:11];
        // IR[4] selects store (MW held for the whole dwell) or load (write back on ready).
        if (bus.IR[4]) begin
          mw_s = 1'b1;
        end else begin
          muxd_s = 5'b00010;
          wr_s   = bus.mem_ready;
        end
        if (bus.mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM;
        end
      end

      ST_HALT: begin
        next_state_s = ST_HALT;
      end

      default: begin
        next_state_s = ST_INIT;
      end
    endcase
  end

  assign bus.PS      = ps_s;
  assign bus.IR_L    = ir_l_s;
  assign bus.AA      = aa_s;
  assign bus.BA      = ba_s;
  assign bus.DA      = da_s;
  assign bus.WR      = wr_s;
  assign bus.Clr     = clr_s;
  assign bus.FS      = fs_s;
  assign bus.Cin     = cin_s;
  assign bus.MuxD    = muxd_s;
  assign bus.MuxA    = muxa_s;
  assign bus.K       = k_s;
  assign bus.MW      = mw_s;
  assign bus.SS      = 2'b00;
  assign bus.state_o = state_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench: two sequencers (zero- and sign-extending immediates) driven in lockstep,
// compared cycle by cycle against control words derived from the instruction semantics.
module tb_cpu_control_fsm;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        mem_ready = 1'b1;
  logic        z = 1'b0;
  logic        n = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_ctrl_if #(.DATA_W(DW)) bus0 ();
  cpu_ctrl_if #(.DATA_W(DW)) bus1 ();

  assign bus0.IR = ir;
  assign bus0.mem_ready = mem_ready;
  assign bus0.Z = z;
  assign bus0.N = n;
  assign bus1.IR = ir;
  assign bus1.mem_ready = mem_ready;
  assign bus1.Z = z;
  assign bus1.N = n;

  cpu_control_fsm #(.DATA_W(DW), .IMM_SIGNED(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cpu_control_fsm #(.DATA_W(DW), .IMM_SIGNED(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic [2:0]    st;
    logic [1:0]    ps;
    logic          ir_l;
    logic [2:0]    aa;
    logic [2:0]    ba;
    logic [2:0]    da;
    logic          wr;
    logic          clr;
    logic [4:0]    fs;
    logic          cin;
    logic [4:0]    muxd;
    logic          muxa;
    logic [DW-1:0] k;
    logic          mw;
    logic [1:0]    ss;
  } cw_t;

  cw_t exp0_q[$], exp1_q[$], obs0_q[$], obs1_q[$];

  function automatic cw_t grab(input logic sel);
    cw_t w;
    if (sel) begin
      w = '{bus1.state_o, bus1.PS, bus1.IR_L, bus1.AA, bus1.BA, bus1.DA, bus1.WR, bus1.Clr,
            bus1.FS, bus1.Cin, bus1.MuxD, bus1.MuxA, bus1.K, bus1.MW, bus1.SS};
    end else begin
      w = '{bus0.state_o, bus0.PS, bus0.IR_L, bus0.AA, bus0.BA, bus0.DA, bus0.WR, bus0.Clr,
            bus0.FS, bus0.Cin, bus0.MuxD, bus0.MuxA, bus0.K, bus0.MW, bus0.SS};
    end
    return w;
  endfunction

  function automatic cw_t idle_word(input logic [2:0] st);
    cw_t w;
    w = '0;
    w.st = st;
    return w;
  endfunction

  function automatic cw_t init_word();
    cw_t w;
    w = idle_word(3'd0);
    w.clr = 1'b1;
    w.ps = 2'd3;
    return w;
  endfunction

  // Two's-complement value of an 11-bit field, widened arithmetically.
  function automatic logic [DW-1:0] sext11(input logic [10:0] v);
    int x;
    x = int'(v);
    if (x >= 1024) x = x - 2048;
    return DW'(x);
  endfunction

  // Execute-cycle control word from the instruction class rules.
  function automatic cw_t exec_word(input logic [15:0] i, input logic zv, input logic nv, input bit sgn);
    cw_t w;
    int  cond;
    bit  taken;
    w = idle_word(3'd2);
    cond = int'(i[13:11]);
    case (int'(i[15:14]))
      0: begin
        w.da = i[13:11]; w.aa = i[10:8]; w.ba = i[7:5];
        w.fs = 5'(i[3:0]); w.cin = i[4]; w.muxd = 5'd1; w.wr = 1'b1; w.ps = 2'd1;
      end
      1: begin
        w.da = i[13:11]; w.aa = i[10:8]; w.ba = i[7:5]; w.ps = 2'd1;
      end
      2: begin
        w.k = sext11(i[10:0]);
        taken = (cond == 0) || (cond == 1 && zv) || (cond == 2 && !zv) || (cond == 3 && nv);
        if (cond == 7) w.ps = 2'd0;
        else w.ps = taken ? 2'd2 : 2'd1;
      end
      default: begin
        w.da = i[13:11];
        w.k = sgn ? sext11(i[10:0]) : DW'(i[10:0]);
        w.fs = 5'd10; w.muxa = 1'b1; w.muxd = 5'd4; w.wr = 1'b1; w.ps = 2'd1;
      end
    endcase
    return w;
  endfunction

  function automatic cw_t mem_word(input logic [15:0] i, input logic rdy);
    cw_t w;
    w = idle_word(3'd3);
    w.da = i[13:11]; w.aa = i[10:8]; w.ba = i[7:5];
    if (i[4]) begin
      w.mw = 1'b1;
    end else begin
      w.muxd = 5'd2;
      w.wr = rdy;
    end
    return w;
  endfunction

  task automatic record();
    obs0_q.push_back(grab(1'b0));
    obs1_q.push_back(grab(1'b1));
  endtask

  // Runs one instruction from FETCH, building the expected word list for both extension modes.
  task automatic run_instr(input logic [15:0] i, input int fw, input int mw, input logic zv, input logic nv);
    cw_t fetch_rdy;
    exp0_q.delete(); exp1_q.delete(); obs0_q.delete(); obs1_q.delete();
    fetch_rdy = idle_word(3'd1);
    fetch_rdy.ir_l = 1'b1;
    for (int c = 0; c < fw; c++) begin
      exp0_q.push_back(idle_word(3'd1)); exp1_q.push_back(idle_word(3'd1));
      @(negedge clk); ir = i; mem_ready = 1'b0; z = 1'($urandom); n = 1'($urandom); #1; record();
    end
    exp0_q.push_back(fetch_rdy); exp1_q.push_back(fetch_rdy);
    @(negedge clk); ir = i; mem_ready = 1'b1; #1; record();
    exp0_q.push_back(exec_word(i, zv, nv, 1'b0)); exp1_q.push_back(exec_word(i, zv, nv, 1'b1));
    @(negedge clk); mem_ready = 1'($urandom); z = zv; n = nv; #1; record();
    if (i[15:14] == 2'b01) begin
      for (int c = 0; c < mw; c++) begin
        exp0_q.push_back(mem_word(i, 1'b0)); exp1_q.push_back(mem_word(i, 1'b0));
        @(negedge clk); mem_ready = 1'b0; z = 1'($urandom); n = 1'($urandom); #1; record();
      end
      exp0_q.push_back(mem_word(i, 1'b1)); exp1_q.push_back(mem_word(i, 1'b1));
      @(negedge clk); mem_ready = 1'b1; #1; record();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (grab(1'b0) !== init_word()) begin bad++; $display("FAIL reset_init dut0 got=%h exp=%h", grab(1'b0), init_word()); end
    total++; if (grab(1'b1) !== init_word()) begin bad++; $display("FAIL reset_init dut1 got=%h exp=%h", grab(1'b1), init_word()); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (bus0.state_o !== 3'd1 || bus0.IR_L !== 1'b1) begin bad++; $display("FAIL reset_fetch got state=%0d ir_l=%0b exp state=1 ir_l=1", bus0.state_o, bus0.IR_L); end
    mem_ready = 1'b0;
  endtask

  task automatic test_alu();
    run_instr(16'h1AB5, 1, 0, 1'b0, 1'b0);
    for (int c = 0; c < exp0_q.size(); c++) begin
      total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL alu dut0 cyc=%0d got=%h exp=%h", c, obs0_q[c], exp0_q[c]); end
      total++; if (obs1_q[c] !== exp1_q[c]) begin bad++; $display("FAIL alu dut1 cyc=%0d got=%h exp=%h", c, obs1_q[c], exp1_q[c]); end
    end
  endtask

  task automatic test_ldi();
    run_instr(16'hC7FF, 0, 0, 1'b0, 1'b0);
    total++; if (obs0_q[1].k !== 16'h07FF) begin bad++; $display("FAIL ldi_zext got=%h exp=07ff", obs0_q[1].k); end
    total++; if (obs1_q[1].k !== 16'hFFFF) begin bad++; $display("FAIL ldi_sext got=%h exp=ffff", obs1_q[1].k); end
    for (int c = 0; c < exp0_q.size(); c++) begin
      total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL ldi dut0 cyc=%0d got=%h exp=%h", c, obs0_q[c], exp0_q[c]); end
      total++; if (obs1_q[c] !== exp1_q[c]) begin bad++; $display("FAIL ldi dut1 cyc=%0d got=%h exp=%h", c, obs1_q[c], exp1_q[c]); end
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] ops [2] = '{16'h4A00, 16'h4A10};
    for (int t = 0; t < 2; t++) begin
      run_instr(ops[t], 0, 3, 1'b0, 1'b0);
      total++; if (obs0_q.size() !== 6) begin bad++; $display("FAIL mem_len got=%0d exp=6", obs0_q.size()); end
      for (int c = 0; c < exp0_q.size(); c++) begin
        total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL mem_wait op=%h dut0 cyc=%0d got=%h exp=%h", ops[t], c, obs0_q[c], exp0_q[c]); end
        total++; if (obs1_q[c] !== exp1_q[c]) begin bad++; $display("FAIL mem_wait op=%h dut1 cyc=%0d got=%h exp=%h", ops[t], c, obs1_q[c], exp1_q[c]); end
      end
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      run_instr(16'h8FFE, 0, 0, 1'(1 - t), 1'b0);
      total++; if (obs0_q[1].ps !== ((t == 0) ? 2'd2 : 2'd1) || obs0_q[1].k !== 16'hFFFE) begin
        bad++; $display("FAIL branch z=%0d got ps=%0d k=%h exp ps=%0d k=fffe", 1 - t, obs0_q[1].ps, obs0_q[1].k, (t == 0) ? 2 : 1);
      end
      for (int c = 0; c < exp0_q.size(); c++) begin
        total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL branch dut0 cyc=%0d got=%h exp=%h", c, obs0_q[c], exp0_q[c]); end
        total++; if (obs1_q[c] !== exp1_q[c]) begin bad++; $display("FAIL branch dut1 cyc=%0d got=%h exp=%h", c, obs1_q[c], exp1_q[c]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i;
    int pc_moves;
    for (int t = 0; t < 40; t++) begin
      i = 16'($urandom);
      if (i[15:14] == 2'b10 && i[13:11] == 3'b111) i[13:11] = 3'($urandom_range(6, 0));
      run_instr(i, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom), 1'($urandom));
      pc_moves = 0;
      for (int c = 0; c < exp0_q.size(); c++) begin
        if (obs0_q[c].ps != 2'd0) pc_moves++;
        total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL rand ir=%h dut0 cyc=%0d got=%h exp=%h", i, c, obs0_q[c], exp0_q[c]); end
        total++; if (obs1_q[c] !== exp1_q[c]) begin bad++; $display("FAIL rand ir=%h dut1 cyc=%0d got=%h exp=%h", i, c, obs1_q[c], exp1_q[c]); end
      end
      total++; if (pc_moves !== 1) begin bad++; $display("FAIL pc_once ir=%h got=%0d exp=1", i, pc_moves); end
    end
  endtask

  task automatic test_mem_abort();
    @(negedge clk); ir = 16'h4A10; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (bus0.state_o !== 3'd3 || bus0.MW !== 1'b1) begin bad++; $display("FAIL abort_pre got state=%0d mw=%0b exp state=3 mw=1", bus0.state_o, bus0.MW); end
    rst_n = 1'b0; #1;
    total++; if (grab(1'b0) !== init_word()) begin bad++; $display("FAIL abort_init got=%h exp=%h", grab(1'b0), init_word()); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (grab(1'b0) !== idle_word(3'd1)) begin bad++; $display("FAIL abort_fetch got=%h exp=%h", grab(1'b0), idle_word(3'd1)); end
  endtask

  task automatic test_halt();
    run_instr(16'hB800, 0, 0, 1'b0, 1'b0);
    for (int c = 0; c < exp0_q.size(); c++) begin
      total++; if (obs0_q[c] !== exp0_q[c]) begin bad++; $display("FAIL halt_seq dut0 cyc=%0d got=%h exp=%h", c, obs0_q[c], exp0_q[c]); end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); mem_ready = 1'($urandom); z = 1'($urandom); #1;
      total++; if (grab(1'b0) !== idle_word(3'd4)) begin bad++; $display("FAIL halt_hold dut0 cyc=%0d got=%h exp=%h", c, grab(1'b0), idle_word(3'd4)); end
      total++; if (grab(1'b1) !== idle_word(3'd4)) begin bad++; $display("FAIL halt_hold dut1 cyc=%0d got=%h exp=%h", c, grab(1'b1), idle_word(3'd4)); end
    end
    rst_n = 1'b0; #1;
    total++; if (grab(1'b0) !== init_word()) begin bad++; $display("FAIL halt_reset got=%h exp=%h", grab(1'b0), init_word()); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (bus0.state_o !== 3'd1) begin bad++; $display("FAIL halt_refetch got=%0d exp=1", bus0.state_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldi();
    test_mem_wait();
    test_branch();
    test_back_to_back();
    test_mem_abort();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
